fpu_op_sequencer: RTL and testbench

//  Issues multi-cycle F-extension ops (FDIV.S, FSQRT.S) to the iterative FPU unit; core keeps running.

---
 rtl/riscv32f_pkg.sv | 15 +
 rtl/fpu_wb_arbiter.sv | 37 +++
 rtl/fpu_op_sequencer.sv | 150 +++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv32f_pkg.sv
// Shared types and constants for the F-extension multi-cycle op sequencer.
// Holds the sequencer FSM state enum and the FP datapath widths.
package riscv32f_pkg;

  localparam int XLEN    = 32;
  localparam int FREG_AW = 5;
  localparam int TMO_CYC = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RETIRE
  } seq_state_e;

endpackage

// File: rtl/fpu_wb_arbiter.sv
// Float register-file write-port mux: load writeback first, FPU result second.
// Purely combinational; idle port drives zeros.
module fpu_wb_arbiter
  import riscv32f_pkg::*;
#(
  parameter int XLEN    = riscv32f_pkg::XLEN,
  parameter int FREG_AW = riscv32f_pkg::FREG_AW
) (
  input  logic               ld_we,
  input  logic [FREG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]    ld_data,
  input  logic               fp_we,
  input  logic [FREG_AW-1:0] fp_rd,
  input  logic [XLEN-1:0]    fp_data,
  output logic               frf_we,
  output logic [FREG_AW-1:0] frf_waddr,
  output logic [XLEN-1:0]    frf_wdata
);

  always_comb begin
    frf_we    = ld_we | fp_we;
    frf_waddr = '0;
    frf_wdata = '0;
    unique case (1'b1)
      ld_we: begin
        frf_waddr = ld_rd;
        frf_wdata = ld_data;
      end
      fp_we: begin
        frf_waddr = fp_rd;
        frf_wdata = fp_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issues FDIV.S/FSQRT.S to the iterative FPU, scoreboards one FP rd, owns frf port.
// Optional EXEC watchdog enabled by defining FPU_SEQ_TIMEOUT_EN.
module fpu_op_sequencer
  import riscv32f_pkg::*;
#(
  parameter int XLEN    = riscv32f_pkg::XLEN,
  parameter int FREG_AW = riscv32f_pkg::FREG_AW,
  parameter int TMO_CYC = riscv32f_pkg::TMO_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_en,
  input  logic               issue_mc,
  input  logic [FREG_AW-1:0] issue_rd,
  input  logic [FREG_AW-1:0] rs1_f,
  input  logic [FREG_AW-1:0] rs2_f,
  input  logic               rs_f_rd,
  input  logic               wr_f,
  input  logic               ld_we,
  input  logic [FREG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]    ld_data,
  output logic               fpu_start,
  input  logic               fpu_done,
  input  logic [XLEN-1:0]    fpu_result,
  output logic               stall,
  output logic               frf_we,
  output logic [FREG_AW-1:0] frf_waddr,
  output logic [XLEN-1:0]    frf_wdata,
  output logic               busy,
  output logic               err_tmo
);

  seq_state_e         state_q, state_d;
  logic [FREG_AW-1:0] pend_rd_q, pend_rd_d;
  logic [XLEN-1:0]    buf_q, buf_d;
  logic               fp_we;
  logic [XLEN-1:0]    fp_data;
  logic               raw_hz, waw_hz, mc_hz;

  always_comb begin
    busy   = (state_q != ST_IDLE);
    raw_hz = rs_f_rd & ((rs1_f == pend_rd_q) | (rs2_f == pend_rd_q));
    waw_hz = wr_f & (issue_rd == pend_rd_q);
    mc_hz  = issue_en & issue_mc;
    stall  = busy & (raw_hz | waw_hz | mc_hz);
  end

`ifdef FPU_SEQ_TIMEOUT_EN
  logic [6:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    buf_d     = buf_q;
    fp_we     = 1'b0;
    fp_data   = buf_q;
    fpu_start = 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (issue_en & issue_mc & ~stall) begin
          fpu_start = 1'b1;
          pend_rd_d = issue_rd;
          state_d   = ST_EXEC;
`ifdef FPU_SEQ_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_EXEC: begin
        if (fpu_done) begin
          buf_d = fpu_result;
          if (!ld_we) begin
            fp_we     = 1'b1;
            fp_data   = fpu_result;
            pend_rd_d = '0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_RETIRE;
          end
`ifdef FPU_SEQ_TIMEOUT_EN
        end else if (cnt_q == 7'(TMO_CYC - 1)) begin
          err_d     = 1'b1;
          pend_rd_d = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
`endif
        end
      end
      ST_RETIRE: begin
        // Load owns the port; the buffered result waits untouched.
        if (!ld_we) begin
          fp_we     = 1'b1;
          pend_rd_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_rd_q <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      buf_q     <= buf_d;
    end
  end

`ifdef FPU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_tmo = err_q;
`else
  assign err_tmo = 1'b0;
`endif

  fpu_wb_arbiter #(
    .XLEN    (XLEN),
    .FREG_AW (FREG_AW)
  ) u_wb_arb (
    .ld_we     (ld_we),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .fp_we     (fp_we),
    .fp_rd     (pend_rd_q),
    .fp_data   (fp_data),
    .frf_we    (frf_we),
    .frf_waddr (frf_waddr),
    .frf_wdata (frf_wdata)
  );

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: scoreboard-level reference plus directed checks.
// Define FPU_SEQ_TIMEOUT_EN to also exercise the EXEC watchdog.
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_en, issue_mc, rs_f_rd, wr_f, ld_we, fpu_done;
  logic [4:0]  issue_rd, rs1_f, rs2_f, ld_rd;
  logic [31:0] ld_data, fpu_result;
  logic        fpu_start, stall, frf_we, busy, err_tmo;
  logic [4:0]  frf_waddr;
  logic [31:0] frf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_mc   (issue_mc),
    .issue_rd   (issue_rd),
    .rs1_f      (rs1_f),
    .rs2_f      (rs2_f),
    .rs_f_rd    (rs_f_rd),
    .wr_f       (wr_f),
    .ld_we      (ld_we),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .fpu_start  (fpu_start),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result),
    .stall      (stall),
    .frf_we     (frf_we),
    .frf_waddr  (frf_waddr),
    .frf_wdata  (frf_wdata),
    .busy       (busy),
    .err_tmo    (err_tmo)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one outstanding op, optionally a held result awaiting the port.
  bit          m_out, m_have, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  int          m_exec;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 0; m_have = 0; m_err = 0; m_rd = '0; m_val = '0; m_exec = 0;
    end else begin
      bit          e_start, e_stall, fp_wr, e_we;
      logic [4:0]  e_ad;
      logic [31:0] e_dt, fp_val;
      e_stall = m_out && ((rs_f_rd && (rs1_f == m_rd || rs2_f == m_rd))
                || (wr_f && issue_rd == m_rd) || (issue_en && issue_mc));
      e_start = !m_out && issue_en && issue_mc;
      fp_wr   = m_out && (m_have || fpu_done) && !ld_we;
      fp_val  = m_have ? m_val : fpu_result;
      e_we    = ld_we || fp_wr;
      e_ad    = ld_we ? ld_rd : (fp_wr ? m_rd : 5'd0);
      e_dt    = ld_we ? ld_data : (fp_wr ? fp_val : 32'd0);
      chk("busy", busy, m_out);
      chk("stall", stall, e_stall);
      chk("fpu_start", fpu_start, e_start);
      chk("frf_we", frf_we, e_we);
      chk("frf_waddr", frf_waddr, e_ad);
      chk("frf_wdata", frf_wdata, e_dt);
      chk("err_tmo", err_tmo, m_err);
      chk("ld_to_pend", m_out && ld_we && ld_rd == m_rd, 0);
      if (fp_wr) begin
        m_out = 0; m_have = 0;
      end else if (m_out && !m_have && fpu_done) begin
        m_have = 1; m_val = fpu_result;
      end else if (m_out && !m_have) begin
`ifdef FPU_SEQ_TIMEOUT_EN
        m_exec++;
        if (m_exec == 64) begin
          m_out = 0; m_err = 1;
        end
`endif
      end
      if (e_start) begin
        m_out = 1; m_rd = issue_rd; m_exec = 0;
      end
    end
  end

  task automatic idle();
    issue_en = 0; issue_mc = 0; issue_rd = 0; rs1_f = 0; rs2_f = 0;
    rs_f_rd = 0; wr_f = 0; ld_we = 0; ld_rd = 0; ld_data = 0;
    fpu_done = 0; fpu_result = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_mc_op(input logic [4:0] rd);
    idle();
    issue_en = 1; issue_mc = 1; issue_rd = rd; wr_f = 1;
  endtask

  initial begin
    int nb;
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start", fpu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_we", frf_we, 0);
    chk("rst_waddr", frf_waddr, 0);
    chk("rst_wdata", frf_wdata, 0);
    chk("rst_err", err_tmo, 0);
    nxt();
    rst_n = 1;
    nxt();

    // FDIV f3, done 10 cycles after issue
    issue_mc_op(5'd3);
    @(negedge clk);
    chk("t1_start", fpu_start, 1);
    nxt();
    idle();
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        fpu_done = 1; fpu_result = 32'h4049_0fdb;
      end
      @(negedge clk);
      if (busy) nb++;
      if (i == 0) chk("t1_start_pulse", fpu_start, 0);
      if (i == 9) begin
        chk("t1_we", frf_we, 1);
        chk("t1_waddr", frf_waddr, 3);
        chk("t1_wdata", frf_wdata, 32'h4049_0fdb);
      end
      nxt();
      idle();
    end
    @(negedge clk);
    chk("t1_idle", busy, 0);
    chk("t1_busy_cycles", nb, 10);
    nxt();

    // FADD reading f3 stalls until the cycle after the retire write
    issue_mc_op(5'd3);
    nxt();
    idle();
    issue_en = 1; rs1_f = 5'd3; rs2_f = 5'd1; rs_f_rd = 1;
    wr_f = 1; issue_rd = 5'd7;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        fpu_done = 1; fpu_result = 32'h3f80_0000;
      end
      @(negedge clk);
      chk("t2_stall", stall, 1);
      nxt();
      fpu_done = 0;
    end
    @(negedge clk);
    chk("t2_release", stall, 0);
    chk("t2_idle", busy, 0);
    nxt();
    idle();

    // done collides with load of f5
    issue_mc_op(5'd3);
    nxt();
    idle();
    nxt();
    fpu_done = 1; fpu_result = 32'h4000_0000;
    ld_we = 1; ld_rd = 5'd5; ld_data = 32'h1234_5678;
    @(negedge clk);
    chk("t3_ld_addr", frf_waddr, 5);
    chk("t3_ld_data", frf_wdata, 32'h1234_5678);
    nxt();
    idle();
    fpu_result = 32'hdead_beef;
    @(negedge clk);
    chk("t3_fp_we", frf_we, 1);
    chk("t3_fp_addr", frf_waddr, 3);
    chk("t3_fp_data", frf_wdata, 32'h4000_0000);
    nxt();
    idle();

    // loads hold the port 3 cycles in RETIRE
    issue_mc_op(5'd4);
    nxt();
    idle();
    fpu_done = 1; fpu_result = 32'h4040_0000;
    ld_we = 1; ld_rd = 5'd6; ld_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_ld_addr", frf_waddr, 6);
      chk("t4_ld_data", frf_wdata, k);
      nxt();
      fpu_done = 0; fpu_result = 32'hffff_0000 + k;
      ld_data = k + 1;
      if (k == 3) ld_we = 0;
    end
    @(negedge clk);
    chk("t4_fp_addr", frf_waddr, 4);
    chk("t4_fp_data", frf_wdata, 32'h4040_0000);
    nxt();
    idle();

    // second multi-cycle op waits for IDLE
    issue_mc_op(5'd3);
    nxt();
    issue_mc_op(5'd9);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        fpu_done = 1; fpu_result = 32'h4110_0000;
      end
      @(negedge clk);
      chk("t5_stall", stall, 1);
      chk("t5_nostart", fpu_start, 0);
      nxt();
      fpu_done = 0;
    end
    @(negedge clk);
    chk("t5_stall_clr", stall, 0);
    chk("t5_start", fpu_start, 1);
    nxt();
    idle();
    nxt();
    rst_n = 0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_we", frf_we, 0);
    chk("t5_rst_start", fpu_start, 0);
    repeat (2) nxt();
    rst_n = 1;
    fpu_done = 1; fpu_result = 32'h1;
    @(negedge clk);
    chk("t5_done_ignored", frf_we, 0);
    chk("t5_post_busy", busy, 0);
    nxt();
    idle();

`ifdef FPU_SEQ_TIMEOUT_EN
    issue_mc_op(5'd2);
    nxt();
    idle();
    repeat (63) nxt();
    @(negedge clk);
    chk("tmo_busy_last", busy, 1);
    chk("tmo_not_yet", err_tmo, 0);
    nxt();
    @(negedge clk);
    chk("tmo_err", err_tmo, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_nowrite", frf_we, 0);
    nxt();
`endif

    repeat (2) nxt();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
